// File: rtl/pic_pkg.sv
// Shared constants for the 8259A read path: FSM state codes, read-select
// encodings, the MCS-80 CALL opcode and ICW/OCW bit positions.
package pic_pkg;

  typedef logic [2:0] pic_state_t;

  localparam pic_state_t IDLE  = 3'd0;
  localparam pic_state_t ACK1  = 3'd1;
  localparam pic_state_t WAIT2 = 3'd2;
  localparam pic_state_t ACK2  = 3'd3;
  localparam pic_state_t WAIT3 = 3'd4;
  localparam pic_state_t ACK3  = 3'd5;

  localparam logic READ_SEL_IRR = 1'b0;
  localparam logic READ_SEL_ISR = 1'b1;

  localparam logic [7:0] CALL_OPCODE = 8'hCD;

  // ICW4 / ICW1 / OCW3 bit indices
  localparam int AEOI = 1;
  localparam int UPM  = 0;
  localparam int ADI  = 2;
  localparam int RR   = 1;
  localparam int RIS  = 0;
  localparam int P    = 2;

endpackage

// File: rtl/pic_priority_resolver.sv
// Rotating-priority encoder: the level just after lowestPri has the highest
// priority; hit is low when no bit of hp is set.
module pic_priority_resolver (
  input  logic [7:0] hp,
  input  logic [2:0] lowestPri,
  output logic       hit,
  output logic [2:0] level
);

  logic [2:0] idx;

  always_comb begin
    hit   = 1'b0;
    level = 3'd0;
    idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = lowestPri + 3'(i + 1);
      if (!hit && hp[idx]) begin
        hit   = 1'b1;
        level = idx;
      end
    end
  end

endmodule

// File: rtl/pic_read_logic.sv
// 8259A read path: status/poll reads and INTA vector sequencing.
// Optional 8080/8085 three-pulse INTA sequence under PIC_MCS80_MODE_EN.
module pic_read_logic
  import pic_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       CS_n,
  input  logic       RD_n,
  input  logic       A0,
  input  logic       INTA_n,
  input  logic [7:0] ICW1,
  input  logic [7:0] ICW2,
  input  logic [7:0] ICW4,
  input  logic [7:0] ocw3,
  input  logic       ocw3Wr,
  input  logic [7:0] IRR,
  input  logic [7:0] ISR,
  input  logic [7:0] IMR,
  input  logic [2:0] lowestPri,
  output logic [7:0] dataOut,
  output logic       dataOutEn,
  output logic       freezeIRR,
  output logic       isrSet,
  output logic [2:0] ackLevel,
  output logic       aeoiPulse
);

  // {INTA_n, CS_n, RD_n} synchronizer chain
  logic [2:0] sync_reg [SYNC_STAGES];

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge clk) begin
        if (!rst_n)
          sync_reg[gi] <= 3'b111;
        else if (gi == 0)
          sync_reg[gi] <= {INTA_n, CS_n, RD_n};
        else
          sync_reg[gi] <= sync_reg[gi-1];
      end
    end
  endgenerate

  logic rd_s, cs_s, inta_s;
  logic rd_prev_reg, inta_prev_reg;
  assign {inta_s, cs_s, rd_s} = sync_reg[SYNC_STAGES-1];

  logic rd_fall, rd_rise, inta_fall, inta_rise;
  assign rd_fall   =  rd_prev_reg   & ~rd_s;
  assign rd_rise   = ~rd_prev_reg   &  rd_s;
  assign inta_fall =  inta_prev_reg & ~inta_s;
  assign inta_rise = ~inta_prev_reg &  inta_s;

  logic [7:0] hp;
  logic       hit;
  logic [2:0] level;
  assign hp = IRR & ~IMR;

  pic_priority_resolver u_resolver (
    .hp        (hp),
    .lowestPri (lowestPri),
    .hit       (hit),
    .level     (level)
  );

  logic mode8080;
  logic [7:0] addr_low;
`ifdef PIC_MCS80_MODE_EN
  assign mode8080 = ~ICW4[UPM];
  assign addr_low = ICW1[ADI] ? {ICW1[7:5], ackLevel, 2'b00} : {ICW1[7:6], ackLevel, 3'b000};
`else
  assign mode8080 = 1'b0;
  assign addr_low = 8'h00;
`endif

  logic unused_ok;
  assign unused_ok = ^{ICW1, ICW2[2:0], ICW4[7:2], ICW4[UPM], ocw3[7:3], addr_low};

  pic_state_t state_reg;
  logic       read_sel_reg, poll_pending_reg, reading_reg, spurious_reg;
  logic       read_start;

  // INTA_n low means inta_s is low, so a coincident INTA always wins
  assign read_start = rd_fall & ~cs_s & inta_s & (state_reg == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_prev_reg      <= 1'b1;
      inta_prev_reg    <= 1'b1;
      state_reg        <= IDLE;
      read_sel_reg     <= READ_SEL_IRR;
      poll_pending_reg <= 1'b0;
      reading_reg      <= 1'b0;
      spurious_reg     <= 1'b0;
      dataOut          <= 8'h00;
      dataOutEn        <= 1'b0;
      freezeIRR        <= 1'b0;
      isrSet           <= 1'b0;
      ackLevel         <= 3'd0;
      aeoiPulse        <= 1'b0;
    end else begin
      rd_prev_reg   <= rd_s;
      inta_prev_reg <= inta_s;
      isrSet        <= 1'b0;
      aeoiPulse     <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (inta_fall) begin
            state_reg   <= ACK1;
            freezeIRR   <= 1'b1;
            reading_reg <= 1'b0;
            if (hit) begin
              ackLevel     <= level;
              isrSet       <= 1'b1;
              spurious_reg <= 1'b0;
            end else begin
              ackLevel     <= 3'd7;
              spurious_reg <= 1'b1;
            end
            if (mode8080) begin
              dataOut   <= CALL_OPCODE;
              dataOutEn <= 1'b1;
            end else begin
              dataOutEn <= 1'b0;
            end
          end else if (read_start) begin
            reading_reg <= 1'b1;
            dataOutEn   <= 1'b1;
            if (poll_pending_reg) begin
              dataOut          <= {hit, 4'b0000, level};
              poll_pending_reg <= 1'b0;
              if (hit) begin
                isrSet   <= 1'b1;
                ackLevel <= level;
              end
            end else if (A0) begin
              dataOut <= IMR;
            end else begin
              dataOut <= (read_sel_reg == READ_SEL_ISR) ? ISR : IRR;
            end
          end else if (reading_reg && rd_rise) begin
            reading_reg <= 1'b0;
            dataOutEn   <= 1'b0;
          end
        end
        ACK1: begin
          if (inta_rise) begin
            state_reg <= WAIT2;
            dataOutEn <= 1'b0;
          end
        end
        WAIT2: begin
          if (inta_fall) begin
            state_reg <= ACK2;
            dataOutEn <= 1'b1;
            dataOut   <= mode8080 ? addr_low : {ICW2[7:3], ackLevel};
          end
        end
        ACK2: begin
          if (inta_rise) begin
            dataOutEn <= 1'b0;
            if (mode8080) begin
              state_reg <= WAIT3;
            end else begin
              state_reg <= IDLE;
              freezeIRR <= 1'b0;
              aeoiPulse <= ICW4[AEOI] & ~spurious_reg;
            end
          end
        end
`ifdef PIC_MCS80_MODE_EN
        WAIT3: begin
          if (inta_fall) begin
            state_reg <= ACK3;
            dataOutEn <= 1'b1;
            dataOut   <= ICW2;
          end
        end
        ACK3: begin
          if (inta_rise) begin
            state_reg <= IDLE;
            dataOutEn <= 1'b0;
            freezeIRR <= 1'b0;
            aeoiPulse <= ICW4[AEOI] & ~spurious_reg;
          end
        end
`endif
        default: state_reg <= IDLE;
      endcase

      // Applied after the read so a new poll command is not lost to a poll read
      if (ocw3Wr) begin
        if (ocw3[RR]) read_sel_reg <= ocw3[RIS];
        if (ocw3[P])  poll_pending_reg <= 1'b1;
      end
    end
  end

endmodule
